hwpe_ctrl_tile_sequencer: RTL and testbench

Job sequencer sitting directly downstream of the HWPE control slave. It consumes the slave's `start` pulse and the job fields from the register file (tile count, base address, stride). It issues the job to the datapath as a sequence of tile requests over a valid/grant handshake, with a bounded number of tiles in flight. When every tile has completed, it returns a single-cycle `done_o`, which drives the slave's `ctrl_i.done`.

---
 rtl/hwpe_ctrl_tile_sequencer.sv | 133 +++++++++++++
 tb/tb_hwpe_ctrl_tile_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_ctrl_tile_sequencer.sv
// Tile sequencer behind the HWPE control slave: issues a job as a stream of tile requests
// with bounded outstanding tiles. Optional busy-cycle counter under HWPE_CTRL_SEQ_PERF_EN.
module hwpe_ctrl_tile_sequencer #(
   parameter int CNT_WIDTH       = 16,
   parameter int ADDR_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clear_i,
   input  logic                  enable_i,
   input  logic                  start_i,
   input  logic [CNT_WIDTH-1:0]  n_tiles_i,
   input  logic [ADDR_WIDTH-1:0] base_addr_i,
   input  logic [ADDR_WIDTH-1:0] stride_i,
   output logic                  tile_req_o,
   input  logic                  tile_gnt_i,
   output logic [ADDR_WIDTH-1:0] tile_addr_o,
   output logic [CNT_WIDTH-1:0]  tile_idx_o,
   input  logic                  tile_done_i,
   output logic                  done_o,
   output logic                  busy_o,
   output logic [31:0]           perf_cycles_o
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam int              OUT_W   = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);
   localparam logic [OUT_W-1:0] OUT_ONE = OUT_W'(1);

   logic [1:0]            state_q;
   logic [CNT_WIDTH-1:0]  n_tiles_q;
   logic [ADDR_WIDTH-1:0] stride_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [CNT_WIDTH-1:0]  issued_q;
   logic [CNT_WIDTH-1:0]  completed_q;
   logic [OUT_W-1:0]      outstanding_q;

   logic                  start_acc;
   logic                  gnt_acc;
   logic                  done_acc;
   logic [CNT_WIDTH-1:0]  completed_nxt;

   // Every output decodes registered state; grant/done only affect the next cycle.
   assign start_acc     = (state_q == IDLE) & start_i & enable_i;
   assign tile_req_o    = (state_q == ISSUE) & (issued_q < n_tiles_q) & (outstanding_q < OUT_MAX);
   assign gnt_acc       = tile_req_o & tile_gnt_i;
   assign done_acc      = (state_q == ISSUE) & tile_done_i & (outstanding_q != '0);
   assign completed_nxt = completed_q + CNT_WIDTH'(done_acc);

   assign tile_addr_o = addr_q;
   assign tile_idx_o  = issued_q;
   assign done_o      = (state_q == DONE);
   assign busy_o      = (state_q != IDLE);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         n_tiles_q     <= '0;
         stride_q      <= '0;
         addr_q        <= '0;
         issued_q      <= '0;
         completed_q   <= '0;
         outstanding_q <= '0;
      end else if (clear_i) begin
         state_q       <= IDLE;
         n_tiles_q     <= '0;
         stride_q      <= '0;
         addr_q        <= '0;
         issued_q      <= '0;
         completed_q   <= '0;
         outstanding_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_acc) begin
                  n_tiles_q     <= n_tiles_i;
                  stride_q      <= stride_i;
                  addr_q        <= base_addr_i;
                  issued_q      <= '0;
                  completed_q   <= '0;
                  outstanding_q <= '0;
                  state_q       <= (n_tiles_i == '0) ? DONE : ISSUE;
               end
            end
            ISSUE: begin
               if (gnt_acc) begin
                  issued_q <= issued_q + CNT_WIDTH'(1);
                  addr_q   <= addr_q + stride_q;
               end
               completed_q <= completed_nxt;
               // Simultaneous grant and completion leave the in-flight count unchanged.
               case ({gnt_acc, done_acc})
                  2'b10:   outstanding_q <= outstanding_q + OUT_ONE;
                  2'b01:   outstanding_q <= outstanding_q - OUT_ONE;
                  default: outstanding_q <= outstanding_q;
               endcase
               if (completed_nxt == n_tiles_q) begin
                  state_q <= DONE;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

`ifdef HWPE_CTRL_SEQ_PERF_EN
   logic [31:0] perf_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_q <= '0;
      end else if (clear_i || start_acc) begin
         perf_q <= '0;
      end else if (busy_o && (perf_q != 32'hFFFF_FFFF)) begin
         perf_q <= perf_q + 32'd1;
      end
   end

   assign perf_cycles_o = perf_q;
`else
   assign perf_cycles_o = '0;
`endif

endmodule

// File: tb/tb_hwpe_ctrl_tile_sequencer.sv
// Directed bench for hwpe_ctrl_tile_sequencer: expected tiles/done pulses are queued at
// stimulus time and popped by a monitor on every granted tile and every done pulse.
module tb_hwpe_ctrl_tile_sequencer;

   localparam int CW = 16;
   localparam int AW = 32;
   localparam int MO = 2;

   logic          clk;
   logic          rst_n;
   logic          clear_i;
   logic          enable_i;
   logic          start_i;
   logic [CW-1:0] n_tiles_i;
   logic [AW-1:0] base_addr_i;
   logic [AW-1:0] stride_i;
   logic          tile_req_o;
   logic          tile_gnt_i;
   logic [AW-1:0] tile_addr_o;
   logic [CW-1:0] tile_idx_o;
   logic          tile_done_i;
   logic          done_o;
   logic          busy_o;
   logic [31:0]   perf_cycles_o;

   int n_vec;
   int n_err;
   logic [CW+AW-1:0] exp_q[$];
   int               done_q[$];

   hwpe_ctrl_tile_sequencer #(
      .CNT_WIDTH      (CW),
      .ADDR_WIDTH     (AW),
      .MAX_OUTSTANDING(MO)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .clear_i      (clear_i),
      .enable_i     (enable_i),
      .start_i      (start_i),
      .n_tiles_i    (n_tiles_i),
      .base_addr_i  (base_addr_i),
      .stride_i     (stride_i),
      .tile_req_o   (tile_req_o),
      .tile_gnt_i   (tile_gnt_i),
      .tile_addr_o  (tile_addr_o),
      .tile_idx_o   (tile_idx_o),
      .tile_done_i  (tile_done_i),
      .done_o       (done_o),
      .busy_o       (busy_o),
      .perf_cycles_o(perf_cycles_o)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         if (tile_req_o && tile_gnt_i) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_grant: got idx %0d addr 0x%0h, expected no tile", tile_idx_o, tile_addr_o);
            end else begin
               check("tile_idx_addr", {16'h0, tile_idx_o, tile_addr_o}, {16'h0, exp_q.pop_front()});
            end
         end
         if (done_o) begin
            n_vec++;
            if (done_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_done: got done_o=1 expected 0");
            end else begin
               void'(done_q.pop_front());
            end
         end
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input logic [CW-1:0] n, input logic [AW-1:0] base, input logic [AW-1:0] stride);
      logic [AW-1:0] a;
      a = base;
      for (int i = 0; i < int'(n); i++) begin
         exp_q.push_back({CW'(i), a});
         a = a + stride;
      end
      done_q.push_back(1);
      n_tiles_i   = n;
      base_addr_i = base;
      stride_i    = stride;
      start_i     = 1'b1;
      tick();
      start_i     = 1'b0;
   endtask

   // Always-grant job; each tile completes one cycle after its grant.
   task automatic auto_job(input logic [CW-1:0] n, input logic [AW-1:0] base, input logic [AW-1:0] stride);
      int out_m;
      int comp;
      out_m = 0;
      comp  = 0;
      start_job(n, base, stride);
      for (int k = 0; k < 200 && comp < int'(n); k++) begin
         tile_gnt_i  = 1'b1;
         tile_done_i = (out_m > 0);
         out_m = out_m + int'(tile_req_o) - int'(tile_done_i);
         comp  = comp + int'(tile_done_i);
         tick();
      end
      tile_gnt_i  = 1'b0;
      tile_done_i = 1'b0;
      if (comp < int'(n)) begin
         n_vec++;
         n_err++;
         $display("FAIL auto_job_timeout: got %0d completions expected %0d", comp, n);
      end
      check("auto_done_pulse", {63'h0, done_o}, 64'h1);
      check("auto_done_busy", {63'h0, busy_o}, 64'h1);
      tick();
      check("auto_after_done", {62'h0, done_o, busy_o}, 64'h0);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      clear_i = 1'b0;
      enable_i = 1'b1;
      start_i = 1'b0;
      n_tiles_i = '0;
      base_addr_i = '0;
      stride_i = '0;
      tile_gnt_i = 1'b0;
      tile_done_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req", {63'h0, tile_req_o}, 64'h0);
      check("rst_addr", {32'h0, tile_addr_o}, 64'h0);
      check("rst_idx", {48'h0, tile_idx_o}, 64'h0);
      check("rst_done_busy", {62'h0, done_o, busy_o}, 64'h0);
      check("rst_perf", {32'h0, perf_cycles_o}, 64'h0);
      rst_n = 1'b1;
      tick();

      // start with enable low is ignored
      enable_i = 1'b0;
      n_tiles_i = 16'd3;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      check("en_low_busy", {62'h0, busy_o, tile_req_o}, 64'h0);
      tick();
      check("en_low_busy2", {63'h0, busy_o}, 64'h0);
      enable_i = 1'b1;

      // spurious done in IDLE
      tile_done_i = 1'b1;
      tick();
      tile_done_i = 1'b0;
      check("idle_spurious", {61'h0, busy_o, done_o, tile_req_o}, 64'h0);

      // basic job: 3 tiles, done two cycles after each grant
      tile_gnt_i = 1'b1;
      start_job(16'd3, 32'h1000, 32'h40);
      check("basic_busy_req", {62'h0, busy_o, tile_req_o}, 64'h3);
      check("basic_t0", {16'h0, tile_idx_o, tile_addr_o}, {32'h0, 32'h1000});
      tick();
      check("basic_t1", {15'h0, tile_req_o, tile_idx_o, tile_addr_o}, {15'h0, 1'b1, 16'd1, 32'h1040});
      tick();
      check("basic_limit", {63'h0, tile_req_o}, 64'h0);
      tile_done_i = 1'b1;
      tick();
      check("basic_t2", {15'h0, tile_req_o, tile_idx_o, tile_addr_o}, {15'h0, 1'b1, 16'd2, 32'h1080});
      tick();
      tile_done_i = 1'b0;
      check("basic_all_issued", {63'h0, tile_req_o}, 64'h0);
      tick();
      check("basic_not_done_yet", {63'h0, done_o}, 64'h0);
      tile_done_i = 1'b1;
      tick();
      tile_done_i = 1'b0;
      tile_gnt_i = 1'b0;
      check("basic_done", {62'h0, done_o, busy_o}, 64'h3);
      tick();
      check("basic_idle", {62'h0, done_o, busy_o}, 64'h0);

      // outstanding limit (MAX_OUTSTANDING = 2), 5 tiles
      tile_gnt_i = 1'b1;
      start_job(16'd5, 32'h0, 32'h4);
      check("lim_t0", {15'h0, tile_req_o, tile_idx_o}, {47'h0, 1'b1, 16'd0});
      tick();
      check("lim_t1", {15'h0, tile_req_o, tile_idx_o}, {47'h0, 1'b1, 16'd1});
      tick();
      check("lim_full_a", {63'h0, tile_req_o}, 64'h0);
      tick();
      check("lim_full_b", {63'h0, tile_req_o}, 64'h0);
      tile_done_i = 1'b1;
      tick();
      tile_done_i = 1'b0;
      check("lim_t2", {15'h0, tile_req_o, tile_idx_o}, {47'h0, 1'b1, 16'd2});
      tick();
      check("lim_full_c", {63'h0, tile_req_o}, 64'h0);
      tile_done_i = 1'b1;
      tick();
      check("lim_t3", {15'h0, tile_req_o, tile_idx_o}, {47'h0, 1'b1, 16'd3});
      tick();
      tile_done_i = 1'b0;
      check("lim_gnt_done_t4", {15'h0, tile_req_o, tile_idx_o}, {47'h0, 1'b1, 16'd4});
      tick();
      check("lim_all_issued", {63'h0, tile_req_o}, 64'h0);
      tile_gnt_i = 1'b0;
      tile_done_i = 1'b1;
      tick();
      check("lim_not_done", {63'h0, done_o}, 64'h0);
      tick();
      tile_done_i = 1'b0;
      check("lim_done", {63'h0, done_o}, 64'h1);
      tick();
      check("lim_idle", {63'h0, busy_o}, 64'h0);

      // handshake stall; done with nothing outstanding is ignored
      tile_gnt_i = 1'b0;
      start_job(16'd2, 32'h2000, 32'h10);
      for (int i = 0; i < 4; i++) begin
         check("stall_hold", {15'h0, tile_req_o, tile_idx_o, tile_addr_o}, {15'h0, 1'b1, 16'd0, 32'h2000});
         tile_done_i = 1'b1;
         tick();
      end
      tile_done_i = 1'b0;
      tile_gnt_i = 1'b1;
      check("stall_gnt_cycle", {15'h0, tile_req_o, tile_idx_o, tile_addr_o}, {15'h0, 1'b1, 16'd0, 32'h2000});
      tick();
      check("stall_advance", {15'h0, tile_req_o, tile_idx_o, tile_addr_o}, {15'h0, 1'b1, 16'd1, 32'h2010});
      tick();
      tile_gnt_i = 1'b0;
      check("stall_issued", {63'h0, tile_req_o}, 64'h0);
      tile_done_i = 1'b1;
      tick();
      check("stall_not_done", {63'h0, done_o}, 64'h0);
      tick();
      tile_done_i = 1'b0;
      check("stall_done", {63'h0, done_o}, 64'h1);
      tick();

      // zero-tile job
      start_job(16'd0, 32'hABC0, 32'h10);
      check("zero_done", {61'h0, done_o, busy_o, tile_req_o}, 64'h6);
      tick();
      check("zero_idle", {62'h0, done_o, busy_o}, 64'h0);

      // address wrap
      auto_job(16'd2, 32'hFFFF_FFC0, 32'h40);

      // clear after two of four tiles
      tile_gnt_i = 1'b1;
      start_job(16'd4, 32'h3000, 32'h8);
      tick();
      tick();
      clear_i = 1'b1;
      tile_gnt_i = 1'b0;
      tick();
      clear_i = 1'b0;
      check("clear_idle", {61'h0, busy_o, done_o, tile_req_o}, 64'h0);
      exp_q.delete();
      done_q.delete();
      tick();
      check("clear_no_done", {63'h0, done_o}, 64'h0);
      auto_job(16'd4, 32'h5000, 32'h20);

      // perf counter: 7 tiles keep the block busy for 9 cycles
      auto_job(16'd7, 32'h100, 32'h4);
      tick();
      tick();
`ifdef HWPE_CTRL_SEQ_PERF_EN
      check("perf_hold", {32'h0, perf_cycles_o}, 64'd9);
`else
      check("perf_tied", {32'h0, perf_cycles_o}, 64'd0);
`endif

      // asynchronous reset mid-job
      tile_gnt_i = 1'b0;
      start_job(16'd3, 32'h7000, 32'h4);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_req_busy_done", {61'h0, tile_req_o, busy_o, done_o}, 64'h0);
      check("arst_addr_idx", {16'h0, tile_idx_o, tile_addr_o}, 64'h0);
      check("arst_perf", {32'h0, perf_cycles_o}, 64'h0);
      exp_q.delete();
      done_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("post_rst_idle", {63'h0, busy_o}, 64'h0);

      check("exp_q_drained", 64'(exp_q.size()), 64'h0);
      check("done_q_drained", 64'(done_q.size()), 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
